// File: rtl/vc_arbiter_pkg.sv
// Shared types and defaults for the VC arbiter: FSM encodings, widths, push pipeline record.
// No logic here; latency and backpressure live in vc_arbiter and vc_arb_grant.
package vc_arbiter_pkg;

   localparam int DATA_WIDTH_DEF = 6;
   localparam int DEST_BIT_DEF   = 4;
   localparam int UMBRAL_W       = 4;

   typedef enum logic [1:0] {
      ST_RESET  = 2'd0,
      ST_INIT   = 2'd1,
      ST_IDLE   = 2'd2,
      ST_ACTIVE = 2'd3
   } state_t;

   // One-deep push pipeline: which VC was popped and where its word goes.
   typedef struct packed {
      logic vld;
      logic dest;
      logic vc;
   } push_pend_t;

endpackage

// File: rtl/vc_arb_grant.sv
// Picks at most one source VC to pop per cycle; combinational grant, no added latency.
// Blocks a VC whose destination is almost full or whose head peek is stale; VC_ARB_RR_EN selects round-robin.
module vc_arb_grant
   import vc_arbiter_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic vc0_empty,
   input  logic vc1_empty,
   input  logic vc0_dest,
   input  logic vc1_dest,
   input  logic d0_almost_full,
   input  logic d1_almost_full,
   output logic vc0_pop,
   output logic vc1_pop
);

   logic req0, req1;
   logic sel0, sel1;
   logic prev0_q, prev1_q;

   assign req0 = en && !vc0_empty && !(vc0_dest ? d1_almost_full : d0_almost_full);
   assign req1 = en && !vc1_empty && !(vc1_dest ? d1_almost_full : d0_almost_full);

`ifdef VC_ARB_RR_EN
   logic last_q;  // 1 = VC1 was granted last

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_q <= 1'b1;
      end else if (vc0_pop || vc1_pop) begin
         last_q <= vc1_pop;
      end
   end

   assign sel1 = req1 && (!req0 || !last_q);
`else
   assign sel1 = req1 && !req0;
`endif
   assign sel0 = req0 && !sel1;

   // The selected VC waits out its stale head peek rather than yielding the slot.
   assign vc0_pop = sel0 && !prev0_q;
   assign vc1_pop = sel1 && !prev1_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev0_q <= 1'b0;
         prev1_q <= 1'b0;
      end else begin
         prev0_q <= vc0_pop;
         prev1_q <= vc1_pop;
      end
   end

endmodule

// File: rtl/vc_arbiter.sv
// Two-VC to two-destination arbiter with threshold config; pop-to-push latency 1 cycle.
// Destination almost_full blocks new pops only; VC_ARB_RR_EN enables round-robin tie-break.
module vc_arbiter
   import vc_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DEST_BIT   = DEST_BIT_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  init,
   input  logic [UMBRAL_W-1:0]   umbral_vc0_in,
   input  logic [UMBRAL_W-1:0]   umbral_vc1_in,
   input  logic [UMBRAL_W-1:0]   umbral_d0_in,
   input  logic [UMBRAL_W-1:0]   umbral_d1_in,
   input  logic                  vc0_empty,
   input  logic                  vc1_empty,
   input  logic [DATA_WIDTH-1:0] vc0_head,
   input  logic [DATA_WIDTH-1:0] vc1_head,
   input  logic [DATA_WIDTH-1:0] vc0_data,
   input  logic [DATA_WIDTH-1:0] vc1_data,
   input  logic                  d0_almost_full,
   input  logic                  d1_almost_full,
   output logic                  vc0_pop,
   output logic                  vc1_pop,
   output logic                  d0_push,
   output logic                  d1_push,
   output logic [DATA_WIDTH-1:0] d0_data,
   output logic [DATA_WIDTH-1:0] d1_data,
   output logic [UMBRAL_W-1:0]   umbral_vc0,
   output logic [UMBRAL_W-1:0]   umbral_vc1,
   output logic [UMBRAL_W-1:0]   umbral_d0,
   output logic [UMBRAL_W-1:0]   umbral_d1,
   output logic [1:0]            state,
   output logic                  idle_out
);

   state_t                state_q, state_d;
   push_pend_t            pend_q;
   logic                  arb_en;
   logic [DATA_WIDTH-1:0] pend_data;
   logic                  unused_head;

   assign unused_head = &{1'b0, vc0_head, vc1_head};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_RESET;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RESET:  state_d = ST_INIT;
         ST_INIT:   if (!init) state_d = ST_IDLE;
         ST_IDLE: begin
            if (init)                           state_d = ST_INIT;
            else if (!vc0_empty || !vc1_empty)  state_d = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (init)                                          state_d = ST_INIT;
            else if (vc0_empty && vc1_empty && !pend_q.vld)    state_d = ST_IDLE;
         end
         default:   state_d = ST_RESET;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         umbral_vc0 <= '0;
         umbral_vc1 <= '0;
         umbral_d0  <= '0;
         umbral_d1  <= '0;
      end else if (state_q == ST_INIT) begin
         umbral_vc0 <= umbral_vc0_in;
         umbral_vc1 <= umbral_vc1_in;
         umbral_d0  <= umbral_d0_in;
         umbral_d1  <= umbral_d1_in;
      end
   end

   assign arb_en = (state_q == ST_ACTIVE) && !init;

   vc_arb_grant u_grant (
      .clk            (clk),
      .reset          (reset),
      .en             (arb_en),
      .vc0_empty      (vc0_empty),
      .vc1_empty      (vc1_empty),
      .vc0_dest       (vc0_head[DEST_BIT]),
      .vc1_dest       (vc1_head[DEST_BIT]),
      .d0_almost_full (d0_almost_full),
      .d1_almost_full (d1_almost_full),
      .vc0_pop        (vc0_pop),
      .vc1_pop        (vc1_pop)
   );

   // Destination is decoded from the head at pop time; data arrives from the FIFO next cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_q <= '0;
      end else begin
         pend_q.vld  <= vc0_pop || vc1_pop;
         pend_q.dest <= vc1_pop ? vc1_head[DEST_BIT] : vc0_head[DEST_BIT];
         pend_q.vc   <= vc1_pop;
      end
   end

   assign pend_data = pend_q.vc ? vc1_data : vc0_data;
   assign d0_push   = pend_q.vld && !pend_q.dest;
   assign d1_push   = pend_q.vld &&  pend_q.dest;
   assign d0_data   = d0_push ? pend_data : '0;
   assign d1_data   = d1_push ? pend_data : '0;

   assign state    = state_q;
   assign idle_out = (state_q == ST_IDLE);

endmodule

// File: tb/tb_vc_arbiter.sv
// Directed bench for vc_arbiter: config window, transfers, tie-break, backpressure, init and reset mid-transfer.
module tb_vc_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       init;
   logic [3:0] umbral_vc0_in, umbral_vc1_in, umbral_d0_in, umbral_d1_in;
   logic       vc0_empty, vc1_empty;
   logic [5:0] vc0_head, vc1_head, vc0_data, vc1_data;
   logic       d0_almost_full, d1_almost_full;
   logic       vc0_pop, vc1_pop, d0_push, d1_push;
   logic [5:0] d0_data, d1_data;
   logic [3:0] umbral_vc0, umbral_vc1, umbral_d0, umbral_d1;
   logic [1:0] state;
   logic       idle_out;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vc_arbiter dut (
      .clk            (clk),
      .reset          (reset),
      .init           (init),
      .umbral_vc0_in  (umbral_vc0_in),
      .umbral_vc1_in  (umbral_vc1_in),
      .umbral_d0_in   (umbral_d0_in),
      .umbral_d1_in   (umbral_d1_in),
      .vc0_empty      (vc0_empty),
      .vc1_empty      (vc1_empty),
      .vc0_head       (vc0_head),
      .vc1_head       (vc1_head),
      .vc0_data       (vc0_data),
      .vc1_data       (vc1_data),
      .d0_almost_full (d0_almost_full),
      .d1_almost_full (d1_almost_full),
      .vc0_pop        (vc0_pop),
      .vc1_pop        (vc1_pop),
      .d0_push        (d0_push),
      .d1_push        (d1_push),
      .d0_data        (d0_data),
      .d1_data        (d1_data),
      .umbral_vc0     (umbral_vc0),
      .umbral_vc1     (umbral_vc1),
      .umbral_d0      (umbral_d0),
      .umbral_d1      (umbral_d1),
      .state          (state),
      .idle_out       (idle_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   logic [1:0] pops;
   assign pops = {vc1_pop, vc0_pop};

   initial begin
      reset = 1'b1; init = 1'b0;
      umbral_vc0_in = 4'd0; umbral_vc1_in = 4'd0; umbral_d0_in = 4'd0; umbral_d1_in = 4'd0;
      vc0_empty = 1'b1; vc1_empty = 1'b1;
      vc0_head = 6'h00; vc1_head = 6'h00; vc0_data = 6'h00; vc1_data = 6'h00;
      d0_almost_full = 1'b0; d1_almost_full = 1'b0;
      #2;
      chk("rst_state",  32'(state), 0);
      chk("rst_umbral", 32'(umbral_vc0), 0);
      chk("rst_io",     32'({pops, d0_push, d1_push, idle_out}), 0);

      // Config window
      cyc(); reset = 1'b0; init = 1'b1;
      umbral_vc0_in = 4'd3; umbral_vc1_in = 4'd5; umbral_d0_in = 4'd7; umbral_d1_in = 4'd9;
      #1; chk("cfg_s0", 32'(state), 0);
      cyc(); #1; chk("cfg_s1", 32'(state), 1);
      cyc(); #1; chk("cfg_s1b", 32'(state), 1);
      chk("cfg_umb_vc0", 32'(umbral_vc0), 3);
      init = 1'b0;
      cyc(); #1; chk("cfg_s2", 32'(state), 2);
      chk("cfg_idle", 32'(idle_out), 1);
      chk("cfg_umb_d1", 32'(umbral_d1), 9);
      chk("cfg_nomove", 32'({pops, d0_push, d1_push}), 0);
      umbral_vc0_in = 4'd12;
      cyc(); #1; chk("umb_hold", 32'(umbral_vc0), 3);

      // Single transfer to D1
      vc0_empty = 1'b0; vc0_head = 6'b010101;
      #1; chk("idle_nopop", 32'(pops), 0);
      cyc(); #1; chk("xfer_state", 32'(state), 3);
      chk("xfer_pop", 32'(pops), 2'b01);
      cyc(); vc0_empty = 1'b1; vc0_data = 6'b010101;
      #1; chk("xfer_push", 32'({d0_push, d1_push}), 2'b01);
      chk("xfer_d1", 32'(d1_data), 32'h15);
      chk("xfer_d0z", 32'(d0_data), 0);
      chk("xfer_nopop", 32'(pops), 0);
      cyc(); #1; chk("xfer_drain", 32'({d0_push, d1_push, 2'(state)}), 32'h3);
      cyc(); #1; chk("xfer_idle", 32'(state), 2);

      // Tie-break, both heads to D0
      vc0_empty = 1'b0; vc1_empty = 1'b0;
      vc0_head = 6'b000011; vc1_head = 6'b000101;
      vc0_data = 6'h03; vc1_data = 6'h05;
      cyc(); #1; chk("tie_p1", 32'(pops), 2'b01);
      cyc(); #1;
`ifdef VC_ARB_RR_EN
      chk("tie_p2", 32'(pops), 2'b10);
`else
      chk("tie_p2", 32'(pops), 2'b00);
`endif
      chk("tie_push", 32'({d0_push, d1_push}), 2'b10);
      chk("tie_d0", 32'(d0_data), 32'h03);
      cyc(); #1; chk("tie_p3", 32'(pops), 2'b01);
`ifdef VC_ARB_RR_EN
      chk("tie_d0b", 32'(d0_data), 32'h05);
`else
      chk("tie_d0b", 32'(d0_data), 32'h00);
`endif
      cyc(); #1;
`ifdef VC_ARB_RR_EN
      chk("tie_p4", 32'(pops), 2'b10);
`else
      chk("tie_p4", 32'(pops), 2'b00);
`endif
      cyc(); vc0_empty = 1'b1; vc1_empty = 1'b1;
      cyc(); cyc(); #1; chk("tie_idle", 32'(state), 2);

      // Backpressure on D0
      d0_almost_full = 1'b1; vc0_empty = 1'b0; vc1_empty = 1'b0;
      vc0_head = 6'b001100; vc1_head = 6'b010000;
      cyc(); #1; chk("af_p1", 32'(pops), 2'b10);
      cyc(); vc1_empty = 1'b1; vc1_data = 6'h30;
      #1; chk("af_p2", 32'(pops), 2'b00);
      chk("af_push", 32'({d1_push, 6'(d1_data)}), 32'h70);
      cyc(); d0_almost_full = 1'b0;
      #1; chk("af_rel", 32'(pops), 2'b01);

      // init rises the cycle after a pop
      cyc(); init = 1'b1; vc0_data = 6'b101100;
      #1; chk("ini_push", 32'({d0_push, d1_push}), 2'b10);
      chk("ini_d0", 32'(d0_data), 32'h2c);
      chk("ini_nopop", 32'(pops), 0);
      cyc(); #1; chk("ini_state", 32'(state), 1);
      chk("ini_nopop2", 32'({pops, d0_push}), 0);
      cyc(); #1; chk("ini_reload", 32'(umbral_vc0), 12);
      chk("ini_nopop3", 32'(pops), 0);

      // reset rises the cycle after a pop
      init = 1'b0;
      cyc(); #1; chk("rs_idle", 32'(state), 2);
      cyc(); #1; chk("rs_pop", 32'(pops), 2'b01);
      cyc(); reset = 1'b1; vc0_data = 6'h3f;
      #1; chk("rs_nopush", 32'({d0_push, d1_push, 6'(d0_data), 6'(d1_data)}), 0);
      chk("rs_state", 32'(state), 0);
      chk("rs_out", 32'({pops, idle_out, umbral_vc0, umbral_vc1, umbral_d0, umbral_d1}), 0);
      cyc(); #1; chk("rs_nopush2", 32'({d0_push, d1_push, pops}), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
